// File: rtl/lsu_ram_ctrl_pkg.sv
// Shared types and constants for the load/store unit and its data RAM.
package lsu_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [7:0] EXC_LD_MISALIGN = 8'h04;
    localparam logic [7:0] EXC_LD_FAULT    = 8'h05;
    localparam logic [7:0] EXC_ST_MISALIGN = 8'h06;
    localparam logic [7:0] EXC_ST_FAULT    = 8'h07;

    // Pick the RISC-V exception code from access direction and fault class.
    function automatic logic [7:0] excCode(input logic isStore, input logic isMisalign);
        logic [7:0] code;
        case ({isStore, isMisalign})
            2'b00:   code = EXC_LD_FAULT;
            2'b01:   code = EXC_LD_MISALIGN;
            2'b10:   code = EXC_ST_FAULT;
            2'b11:   code = EXC_ST_MISALIGN;
            default: code = EXC_ST_FAULT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lsu_ram_ctrl_byte_lane_ram.sv
// Byte-lane data RAM: one independent 8-bit array per lane, synchronous
// per-lane write, registered read followed by RD_LAT-1 extra pipeline stages.
module byte_lane_ram #(
    parameter int DATA_W    = 32,
    parameter int RAM_BYTES = 256,
    parameter int RD_LAT    = 1,
    parameter int LANES     = DATA_W / 8,
    parameter int IDX_W     = ((RAM_BYTES / LANES) > 1) ? $clog2(RAM_BYTES / LANES) : 1
) (
    input  logic              clk,
    input  logic [LANES-1:0]  wrEn,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [DATA_W-1:0] wrData,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic [DATA_W-1:0] rdData
);

    localparam int DEPTH = RAM_BYTES / LANES;

    logic [7:0]        mem_r    [LANES][DEPTH];
    logic [DATA_W-1:0] rdPipe_r [RD_LAT];

    // Lane writes: each lane commits only its own byte when enabled.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wrEn[l]) begin
                mem_r[l][wrIdx] <= wrData[8*l +: 8];
            end
        end
    end

    // Registered read of all lanes, then a plain delay line to reach RD_LAT.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            rdPipe_r[0][8*l +: 8] <= mem_r[l][rdIdx];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            rdPipe_r[k] <= rdPipe_r[k-1];
        end
    end

    assign rdData = rdPipe_r[RD_LAT-1];

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store controller with integrated byte-lane RAM. One request at a time:
// IDLE accepts, BUSY performs the access (and waits out the read latency),
// RESP holds the response until the consumer takes it.
module lsu_ram_ctrl
    import lsu_ram_ctrl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RAM_BYTES = 256,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_exc,
    output logic [7:0]        rsp_excode
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int DEPTH  = RAM_BYTES / LANES;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = 2;

    lsu_state_e        state_r, nextState_s;
    logic              reqWe_r, reqUns_r;
    mem_size_e         reqSize_r;
    logic [ADDR_W-1:0] reqAddr_r;
    logic [DATA_W-1:0] reqWdata_r;
    logic [CNT_W-1:0]  busyCnt_r;

    logic              reqReady_r, rspValid_r, rspExc_r;
    logic [DATA_W-1:0] rspRdata_r;
    logic [7:0]        rspExcode_r;

    logic              accept_s, leaveBusy_s;
    logic              sizeBad_s, misAlign_s, outRange_s, fault_s;
    logic [2:0]        sizeMask_s;
    logic [3:0]        nBytes_s;
    logic [ADDR_W:0]   accessEnd_s;
    logic [LANE_W-1:0] lane_s;
    logic [LANES-1:0]  byteEn_s, wrEn_s;
    logic [DATA_W-1:0] wrData_s, ramRd_s, shifted_s, loadData_s;
    logic [IDX_W-1:0]  rdIdx_s;
    logic [7:0]        faultCode_s;

    // Shift-aligned load data extended from the access width; full width passes through.
    function automatic logic [DATA_W-1:0] extendLoad(input logic [DATA_W-1:0] d,
                                                     input mem_size_e sz,
                                                     input logic uns);
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] res;
        int                nBits;
        nBits = 8 << int'(sz);
        if (nBits >= DATA_W) begin
            res = d;
        end else begin
            mask = (DATA_W'(1) << nBits) - DATA_W'(1);
            res  = (d & mask) | ((!uns && d[nBits-1]) ? ~mask : '0);
        end
        return res;
    endfunction

    assign accept_s = req_valid && (state_r == IDLE);
    assign lane_s   = reqAddr_r[LANE_W-1:0];

    // Check the registered request and build byte enables and replicated store data.
    always_comb begin
        nBytes_s    = 4'd1 << reqSize_r;
        sizeMask_s  = (3'd1 << reqSize_r) - 3'd1;
        accessEnd_s = {1'b0, reqAddr_r} + ((ADDR_W+1)'(1) << reqSize_r);
        sizeBad_s   = (reqSize_r == MEM_D) && (DATA_W == 32);
        misAlign_s  = (reqAddr_r[2:0] & sizeMask_s) != 3'd0;
        outRange_s  = accessEnd_s > (ADDR_W+1)'(RAM_BYTES);
        fault_s     = sizeBad_s || misAlign_s || outRange_s;
        faultCode_s = excCode(reqWe_r, !sizeBad_s && misAlign_s);
        byteEn_s    = '0;
        wrData_s    = '0;
        for (int i = 0; i < LANES; i++) begin
            byteEn_s[i]        = (i >= int'(lane_s)) && (i < int'(lane_s) + int'(nBytes_s));
            wrData_s[8*i +: 8] = reqWdata_r[8*(i & (int'(nBytes_s) - 1)) +: 8];
        end
    end

    // A store commits on its single BUSY edge unless it faults or reset wins that edge.
    assign wrEn_s = (state_r == BUSY && busyCnt_r == CNT_W'(0) && reqWe_r && !fault_s && !rst)
                    ? byteEn_s : '0;

    // Read address follows the incoming request at accept so data lines up with RD_LAT.
    assign rdIdx_s = (state_r == IDLE) ? req_addr[LANE_W +: IDX_W] : reqAddr_r[LANE_W +: IDX_W];

    byte_lane_ram #(
        .DATA_W    (DATA_W),
        .RAM_BYTES (RAM_BYTES),
        .RD_LAT    (RD_LAT),
        .LANES     (LANES),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk    (clk),
        .wrEn   (wrEn_s),
        .wrIdx  (reqAddr_r[LANE_W +: IDX_W]),
        .wrData (wrData_s),
        .rdIdx  (rdIdx_s),
        .rdData (ramRd_s)
    );

    assign shifted_s   = ramRd_s >> {lane_s, 3'b000};
    assign loadData_s  = extendLoad(shifted_s, reqSize_r, reqUns_r);
    assign leaveBusy_s = fault_s || reqWe_r || (busyCnt_r == CNT_W'(RD_LAT - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:    nextState_s = accept_s ? BUSY : IDLE;
            BUSY:    nextState_s = leaveBusy_s ? RESP : BUSY;
            RESP:    nextState_s = rsp_ready ? IDLE : RESP;
            default: nextState_s = IDLE;
        endcase
    end

    // Capture the request on accept; it is the only time inputs are looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqWe_r    <= 1'b0;
            reqUns_r   <= 1'b0;
            reqSize_r  <= MEM_B;
            reqAddr_r  <= '0;
            reqWdata_r <= '0;
        end else if (accept_s) begin
            reqWe_r    <= req_we;
            reqUns_r   <= req_unsigned;
            reqSize_r  <= mem_size_e'(req_size);
            reqAddr_r  <= req_addr;
            reqWdata_r <= req_wdata;
        end
    end

    // Count BUSY cycles so an OK load leaves after exactly RD_LAT of them.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            busyCnt_r <= '0;
        end else if (state_r == BUSY) begin
            busyCnt_r <= busyCnt_r + CNT_W'(1);
        end
    end

    // Response registers: loaded when leaving BUSY and frozen while presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqReady_r  <= 1'b1;
            rspValid_r  <= 1'b0;
            rspRdata_r  <= '0;
            rspExc_r    <= 1'b0;
            rspExcode_r <= 8'h00;
        end else begin
            reqReady_r <= (nextState_s == IDLE);
            if (state_r == BUSY && leaveBusy_s) begin
                rspValid_r  <= 1'b1;
                rspRdata_r  <= (fault_s || reqWe_r) ? '0 : loadData_s;
                rspExc_r    <= fault_s;
                rspExcode_r <= fault_s ? faultCode_s : 8'h00;
            end else if (state_r == RESP && rsp_ready) begin
                rspValid_r <= 1'b0;
            end
        end
    end

    assign req_ready  = reqReady_r;
    assign rsp_valid  = rspValid_r;
    assign rsp_rdata  = rspRdata_r;
    assign rsp_exc    = rspExc_r;
    assign rsp_excode = rspExcode_r;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Scoreboard bench for lsu_ram_ctrl: directed requests push expected responses,
// a monitor pops and compares each response as it appears.
module tb_lsu_ram_ctrl;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_exc;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_excode;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        exc;
        logic [7:0]  code;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    logic expectIdle = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    lsu_ram_ctrl #(
        .DATA_W(32), .ADDR_W(32), .RAM_BYTES(256), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_exc(rsp_exc), .rsp_excode(rsp_excode)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Drive one request when the DUT is ready; optionally push its expected response.
    task automatic issue(input string name, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] expData, input logic expExc, input logic [7:0] expCode,
                         input bit push);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check({name, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
        if (push) begin
            e.name  = name;
            e.rdata = expData;
            e.exc   = expExc;
            e.code  = expCode;
            e.lat   = (!we && !expExc) ? RD_LAT : 1;
            e.acc   = cycle;
            sbQ.push_back(e);
        end
    endtask

    // Monitor: compare new responses against the scoreboard, then check they stay frozen.
    initial begin
        logic        prevValid;
        exp_t        cur;
        logic [31:0] hData;
        logic        hExc;
        logic [7:0]  hCode;
        prevValid = 1'b0;
        hData = 32'd0; hExc = 1'b0; hCode = 8'd0;
        forever begin
            @(negedge clk);
            if (expectIdle) begin
                check("idle_req_ready", {31'd0, req_ready}, 32'd1);
                check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                check("idle_rsp_rdata", rsp_rdata, 32'd0);
                check("idle_rsp_exc", {31'd0, rsp_exc}, 32'd0);
                check("idle_rsp_excode", {24'd0, rsp_excode}, 32'd0);
            end
            if (rsp_valid && !prevValid) begin
                if (sbQ.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    cur = sbQ.pop_front();
                    check({cur.name, "_lat"}, 32'(cycle - cur.acc), 32'(cur.lat));
                    check({cur.name, "_rdata"}, rsp_rdata, cur.rdata);
                    check({cur.name, "_exc"}, {31'd0, rsp_exc}, {31'd0, cur.exc});
                    if (cur.exc) check({cur.name, "_excode"}, {24'd0, rsp_excode}, {24'd0, cur.code});
                end
                hData = rsp_rdata; hExc = rsp_exc; hCode = rsp_excode;
            end else if (rsp_valid) begin
                check("hold_rdata", rsp_rdata, hData);
                check("hold_exc", {31'd0, rsp_exc}, {31'd0, hExc});
                check("hold_excode", {24'd0, rsp_excode}, {24'd0, hCode});
                check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            prevValid = rsp_valid;
        end
    end

    // Directed stimulus.
    initial begin
        int guard;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 expectIdle = 1'b1;
        @(posedge clk);
        #1 expectIdle = 1'b0;
        rst = 1'b0;

        // word store then load back
        issue("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 8'h00, 1'b1);
        issue("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1);
        // sub-word loads with extension
        issue("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 8'h00, 1'b1);
        issue("lbu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 8'h00, 1'b1);
        issue("lh_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 8'h00, 1'b1);
        issue("lhu_10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 8'h00, 1'b1);
        // misaligned accesses
        issue("sh_11", 1'b1, 2'd1, 1'b0, 32'h11, 32'h1111, 32'h0, 1'b1, 8'h06, 1'b1);
        issue("lw_10_b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1);
        issue("lw_12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 8'h04, 1'b1);
        // byte store into top lane, illegal double
        issue("sb_13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h77, 32'h0, 1'b0, 8'h00, 1'b1);
        issue("lw_10_c", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h77ADBEEF, 1'b0, 8'h00, 1'b1);
        issue("ld_18", 1'b0, 2'd3, 1'b0, 32'h18, 32'h0, 32'h0, 1'b1, 8'h05, 1'b1);
        // top of RAM and out of range
        issue("sw_fc", 1'b1, 2'd2, 1'b0, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 8'h00, 1'b1);
        issue("lw_fc", 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 8'h00, 1'b1);
        issue("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 8'h05, 1'b1);
        issue("sb_ffffffff", 1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h11, 32'h0, 1'b1, 8'h07, 1'b1);
        issue("lw_fc_b", 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 8'h00, 1'b1);
        issue("sh_fe", 1'b1, 2'd1, 1'b0, 32'hFE, 32'h8001, 32'h0, 1'b0, 8'h00, 1'b1);
        issue("lh_fe", 1'b0, 2'd1, 1'b0, 32'hFE, 32'h0, 32'hFFFF8001, 1'b0, 8'h00, 1'b1);
        issue("lw_fc_c", 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 32'h8001F00D, 1'b0, 8'h00, 1'b1);

        // back-pressure: response held, stray request ignored
        issue("sw_30", 1'b1, 2'd2, 1'b0, 32'h30, 32'hA5A5A5A5, 32'h0, 1'b0, 8'h00, 1'b1);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        rsp_ready = 1'b0;
        issue("lw_hold", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h77ADBEEF, 1'b0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b1;
        issue("lw_30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0, 8'h00, 1'b1);

        // reset on the store's write edge
        issue("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 8'h00, 1'b1);
        issue("sw_20_rst", 1'b1, 2'd2, 1'b0, 32'h20, 32'h00000055, 32'h0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 expectIdle = 1'b1;
        @(posedge clk);
        #1 expectIdle = 1'b0;
        rst = 1'b0;
        issue("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 8'h00, 1'b1);

        guard = 0;
        while (sbQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("drain", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
